// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - XLEN operand/result width (only 32 is supported)
//   - funct3 encodings of the eight M-extension operations
//   - the controller state enum
//   - small decode helpers (is_div, is_rem, a_signed, b_signed) and the
//     final result-word selector shared by the normal and cached paths
// ---------------------------------------------------------------------------
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } MulDivState;

   // Upper funct3 bit separates the divide family from the multiply family.
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_rem(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   // MUL is treated as signed x signed so that its 64-bit product is the
   // same one MULH would need; the low word is identical either way.
   function automatic logic a_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // The high word holds the upper product half or the remainder, the low
   // word holds the lower product half or the quotient.
   function automatic logic [XLEN-1:0] selectResult(input logic [2:0]      op,
                                                    input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo);
      logic [XLEN-1:0] sel;
      if (op[2])
         sel = op[1] ? hi : lo;
      else
         sel = (op == OP_MUL) ? lo : hi;
      return sel;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the shared multiply/divide datapath.
// The {hi, lo} pair is the working accumulator.
//   Multiply (radix-2 shift-add): lo starts as the multiplier; when lo[0]
//   is set the multiplicand is added into hi, then the whole pair shifts
//   right one place.
//   Divide (restoring): lo starts as the dividend; the pair shifts left,
//   the divisor is trial-subtracted from the partial remainder in hi, and
//   the resulting quotient bit enters lo[0].
// Ports:
//   i_isDiv  select divide step (1) or multiply step (0)
//   i_hi     accumulator high word (partial product / partial remainder)
//   i_lo     accumulator low word (multiplier / dividend-quotient)
//   i_opnd   multiplicand magnitude or divisor magnitude
//   o_hi     next high word
//   o_lo     next low word
// ---------------------------------------------------------------------------
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic            i_isDiv,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_opnd,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_sum;
   logic [XLEN:0] w_shifted;
   logic [XLEN:0] w_diff;
   logic          w_fits;

   // The add keeps its carry so the right shift does not lose the top bit;
   // the shifted partial remainder needs one extra bit for the same reason.
   always_comb begin
      w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
      w_shifted = {i_hi, i_lo[XLEN-1]};
      w_fits    = (w_shifted >= {1'b0, i_opnd});
      w_diff    = w_shifted - {1'b0, i_opnd};
      o_hi      = w_sum[XLEN:1];
      o_lo      = {w_sum[0], i_lo[XLEN-1:1]};
      if (i_isDiv) begin
         o_hi = w_fits ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
         o_lo = {i_lo[XLEN-2:0], w_fits};
      end
   end

endmodule

// File: rtl/exe_muldiv_unit.sv
// ---------------------------------------------------------------------------
// exe_muldiv_unit
// Iterative RV32M multiply/divide unit in the EXE stage. Operands, op and
// destination tag come straight from the ID/EXE register; the unit raises
// a combinational stall while working and pulses done for one cycle with
// the registered result and tag. Normal ops take 32 CALC iterations plus a
// FIXUP cycle; divide-by-zero and signed overflow finish immediately.
// Optional build macro: MULDIV_RESULT_CACHE_EN keeps the last normally
// completed operands/product or quotient+remainder so a matching request
// (e.g. REM after DIV on the same operands) completes without iterating.
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   start   ID/EXE holds an M-extension op (stable while stall=1)
//   kill    pipeline flush, aborts any operation in flight
//   op      funct3 of the operation
//   a, b    rs1 / rs2 operands
//   rd_in   destination register
//   stall   hold ID/EXE and front end
//   done    one-cycle result-valid pulse
//   result  registered result
//   rd_out  registered destination tag, valid with done
// ---------------------------------------------------------------------------
module exe_muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   MulDivState      r_state;
   MulDivState      w_nextState;
   logic [4:0]      r_count;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_opnd;
   logic [2:0]      r_op;
   logic            r_negLo;
   logic            r_negHi;
   logic [XLEN-1:0] r_result;
   logic [4:0]      r_rdOut;

   logic            w_accept;
   logic            w_aNeg;
   logic            w_bNeg;
   logic [XLEN-1:0] w_absA;
   logic [XLEN-1:0] w_absB;
   logic            w_divZero;
   logic            w_overflow;
   logic            w_special;
   logic [XLEN-1:0] w_specialResult;
   logic            w_cacheHit;
   logic [XLEN-1:0] w_cacheResult;
   logic [XLEN-1:0] w_stepHi;
   logic [XLEN-1:0] w_stepLo;
   logic [2*XLEN-1:0] w_prodNeg;
   logic [XLEN-1:0] w_fixHi;
   logic [XLEN-1:0] w_fixLo;

   // Request decode in IDLE: operand magnitudes, sign flags and the two
   // special divide cases that bypass the iteration entirely.
   always_comb begin
      w_accept   = (r_state == IDLE) && start && !kill;
      w_aNeg     = a_signed(op) & a[XLEN-1];
      w_bNeg     = b_signed(op) & b[XLEN-1];
      w_absA     = w_aNeg ? (~a + 1'b1) : a;
      w_absB     = w_bNeg ? (~b + 1'b1) : b;
      w_divZero  = is_div(op) && (b == '0);
      w_overflow = is_div(op) && a_signed(op) && (a == MOST_NEG) && (b == '1);
      w_special  = w_divZero || w_overflow;
      if (w_divZero)
         w_specialResult = is_rem(op) ? a : '1;
      else
         w_specialResult = is_rem(op) ? '0 : MOST_NEG;
   end

   muldiv_step u_step (
      .i_isDiv (is_div(r_op)),
      .i_hi    (r_hi),
      .i_lo    (r_lo),
      .i_opnd  (r_opnd),
      .o_hi    (w_stepHi),
      .o_lo    (w_stepLo)
   );

   // Sign correction after the last iteration. The product is negated as a
   // 64-bit whole; quotient and remainder are negated independently.
   always_comb begin
      w_prodNeg = ~{r_hi, r_lo} + 1'b1;
      if (is_div(r_op)) begin
         w_fixLo = r_negLo ? (~r_lo + 1'b1) : r_lo;
         w_fixHi = r_negHi ? (~r_hi + 1'b1) : r_hi;
      end else begin
         w_fixHi = r_negLo ? w_prodNeg[2*XLEN-1:XLEN] : r_hi;
         w_fixLo = r_negLo ? w_prodNeg[XLEN-1:0]      : r_lo;
      end
   end

`ifdef MULDIV_RESULT_CACHE_EN
   logic            r_cacheValid;
   logic [XLEN-1:0] r_cacheA;
   logic [XLEN-1:0] r_cacheB;
   logic [2:0]      r_cacheCls;
   logic [XLEN-1:0] r_cacheHi;
   logic [XLEN-1:0] r_cacheLo;
   logic [XLEN-1:0] r_rawA;
   logic [XLEN-1:0] r_rawB;
   logic [2:0]      r_cls;
   logic [2:0]      w_cls;

   // Class packs family and operand signedness, so MUL/MULH share an entry
   // and DIV/REM share an entry while MULHU or DIVU never alias them.
   always_comb begin
      w_cls         = {is_div(op), a_signed(op), b_signed(op)};
      w_cacheHit    = r_cacheValid && (a == r_cacheA) && (b == r_cacheB) &&
                      (w_cls == r_cacheCls);
      w_cacheResult = selectResult(op, r_cacheHi, r_cacheLo);
   end

   // Raw operands are captured at acceptance and the entry is written only
   // when an iterated operation completes; kill leaves the entry alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cacheValid <= 1'b0;
         r_cacheA     <= '0;
         r_cacheB     <= '0;
         r_cacheCls   <= '0;
         r_cacheHi    <= '0;
         r_cacheLo    <= '0;
         r_rawA       <= '0;
         r_rawB       <= '0;
         r_cls        <= '0;
      end else begin
         if (w_accept) begin
            r_rawA <= a;
            r_rawB <= b;
            r_cls  <= w_cls;
         end
         if ((r_state == FIXUP) && !kill) begin
            r_cacheValid <= 1'b1;
            r_cacheA     <= r_rawA;
            r_cacheB     <= r_rawB;
            r_cacheCls   <= r_cls;
            r_cacheHi    <= w_fixHi;
            r_cacheLo    <= w_fixLo;
         end
      end
   end
`else
   always_comb begin
      w_cacheHit    = 1'b0;
      w_cacheResult = '0;
   end
`endif

   // Controller state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   // Next-state and stall. kill wins over start and over completion; DONE
   // drops stall so the pipeline advances in the same cycle the result is
   // valid, and the still-present start is ignored there.
   always_comb begin
      w_nextState = r_state;
      stall       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               stall       = 1'b1;
               w_nextState = (w_special || w_cacheHit) ? DONE : CALC;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (kill)
               w_nextState = IDLE;
            else if (r_count == 5'd0)
               w_nextState = FIXUP;
         end
         FIXUP: begin
            stall       = 1'b1;
            w_nextState = kill ? IDLE : DONE;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath registers: load magnitudes on acceptance, iterate in CALC,
   // and register the selected, sign-corrected word in FIXUP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_op     <= '0;
         r_negLo  <= 1'b0;
         r_negHi  <= 1'b0;
         r_result <= '0;
         r_rdOut  <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= op;
            r_rdOut <= rd_in;
            if (w_special) begin
               r_result <= w_specialResult;
            end else if (w_cacheHit) begin
               r_result <= w_cacheResult;
            end else begin
               r_count <= 5'd31;
               r_hi    <= '0;
               r_lo    <= is_div(op) ? w_absA : w_absB;
               r_opnd  <= is_div(op) ? w_absB : w_absA;
               r_negLo <= w_aNeg ^ w_bNeg;
               r_negHi <= is_div(op) ? w_aNeg : (w_aNeg ^ w_bNeg);
            end
         end
         if ((r_state == CALC) && !kill) begin
            r_hi    <= w_stepHi;
            r_lo    <= w_stepLo;
            r_count <= r_count - 5'd1;
         end
         if ((r_state == FIXUP) && !kill)
            r_result <= selectResult(r_op, w_fixHi, w_fixLo);
      end
   end

   assign done   = (r_state == DONE);
   assign result = r_result;
   assign rd_out = r_rdOut;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_exe_muldiv_unit
// Self-checking bench for exe_muldiv_unit: a vector table of RV32M ops with
// expected results, a scoreboard queue of expected {result, rd, latency},
// a small cache model that predicts single-cycle hits when the unit is
// built with MULDIV_RESULT_CACHE_EN, and hand-written kill / reset
// sequences.
// ---------------------------------------------------------------------------
module tb_exe_muldiv_unit;

   logic        clk;
   logic        rstN;
   logic        start;
   logic        kill;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rdIn;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rdOut;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] expResult;
   } Vector;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      int          latency;
   } Expect;

   Vector vectors[17];
   Expect scoreboard[$];

   // Bench-side model of the single-entry result cache.
   logic        mdlValid;
   logic [31:0] mdlA;
   logic [31:0] mdlB;
   int          mdlCls;

   exe_muldiv_unit dut (
      .clk    (clk),
      .rst    (rstN),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .rd_in  (rdIn),
      .stall  (stall),
      .done   (done),
      .result (result),
      .rd_out (rdOut)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int opClass(input logic [2:0] o);
      case (o)
         3'b000, 3'b001: return 1;
         3'b010:         return 2;
         3'b011:         return 3;
         3'b100, 3'b110: return 4;
         default:        return 5;
      endcase
   endfunction

   // Drives one operation from an IDLE cycle, holds start until done and
   // checks stall, result, tag and latency against the scoreboard entry.
   task automatic applyStimulus(input logic [2:0] vOp, input logic [31:0] vA,
                                input logic [31:0] vB, input logic [4:0] vRd,
                                input logic [31:0] vExp, input string name);
      Expect e;
      Expect got;
      bit    special;
      bit    hit;
      int    cycles;
      int    earlyLow;
      bit    seen;
      special = (vOp[2] && vB == 32'h0) ||
                ((vOp == 3'b100 || vOp == 3'b110) &&
                 vA == 32'h8000_0000 && vB == 32'hFFFF_FFFF);
      hit = 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
      hit = mdlValid && mdlA == vA && mdlB == vB && mdlCls == opClass(vOp);
`endif
      e.result  = vExp;
      e.rd      = vRd;
      e.latency = (special || hit) ? 1 : 34;
      if (!special && !hit) begin
         mdlValid = 1'b1;
         mdlA     = vA;
         mdlB     = vB;
         mdlCls   = opClass(vOp);
      end
      scoreboard.push_back(e);

      op    = vOp;
      a     = vA;
      b     = vB;
      rdIn  = vRd;
      start = 1'b1;
      #1;
      checkOutput({name, "_stallC0"}, {31'b0, stall}, 32'd1);
      cycles   = 0;
      earlyLow = 0;
      seen     = 1'b0;
      while (!seen && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
         if (done)
            seen = 1'b1;
         else if (!stall)
            earlyLow++;
      end
      if (!seen) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL %s_timeout: no done after %0d cycles, expected done", name, cycles);
         void'(scoreboard.pop_front());
      end else begin
         got = scoreboard.pop_front();
         checkOutput({name, "_result"}, result, got.result);
         checkOutput({name, "_rd"}, {27'b0, rdOut}, {27'b0, got.rd});
         checkOutput({name, "_latency"}, cycles, got.latency);
         checkOutput({name, "_stallHeld"}, earlyLow, 32'd0);
         checkOutput({name, "_stallDone"}, {31'b0, stall}, 32'd0);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({name, "_donePulse"}, {31'b0, done}, 32'd0);
   endtask

   // Counts done pulses over a window; used after kill and reset.
   task automatic watchNoDone(input int nCycles, input string name);
      int pulses;
      pulses = 0;
      for (int i = 0; i < nCycles; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      checkOutput(name, pulses, 32'd0);
   endtask

   initial begin
      vectors[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      vectors[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
      vectors[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000};
      vectors[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF};
      vectors[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD};
      vectors[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF};
      vectors[6]  = '{3'b101, 32'd100,        32'd7,         5'd11, 32'd14};
      vectors[7]  = '{3'b111, 32'd100,        32'd7,         5'd12, 32'd2};
      vectors[8]  = '{3'b101, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF};
      vectors[9]  = '{3'b110, 32'd5,          32'd0,         5'd14, 32'd5};
      vectors[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000};
      vectors[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0};
      vectors[12] = '{3'b000, 32'h0001_0000,  32'h0001_0000, 5'd17, 32'd0};
      vectors[13] = '{3'b001, 32'h0001_0000,  32'h0001_0000, 5'd18, 32'd1};
      vectors[14] = '{3'b011, 32'h0001_0000,  32'h0001_0000, 5'd19, 32'd1};
      vectors[15] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD};
      vectors[16] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd21, 32'd1};

      mdlValid = 1'b0;
      mdlA     = '0;
      mdlB     = '0;
      mdlCls   = 0;
      rstN  = 1'b0;
      start = 1'b0;
      kill  = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      rdIn  = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_done",   {31'b0, done},  32'd0);
      checkOutput("reset_result", result,         32'd0);
      checkOutput("reset_rd",     {27'b0, rdOut}, 32'd0);
      checkOutput("reset_stall",  {31'b0, stall}, 32'd0);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++)
         applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, vectors[i].rd,
                       vectors[i].expResult, $sformatf("vec%0d", i));

      // Flush a DIVU in its tenth cycle: stall drops at once and the
      // aborted operation never reports.
      op    = 3'b101;
      a     = 32'd1000;
      b     = 32'd3;
      rdIn  = 5'd22;
      start = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      kill  = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("kill_stall", {31'b0, stall}, 32'd0);
      checkOutput("kill_done",  {31'b0, done},  32'd0);
      kill = 1'b0;
      watchNoDone(40, "kill_noDone");
      applyStimulus(3'b000, 32'd3, 32'd4, 5'd23, 32'd12, "afterKill");

      // Asynchronous reset in cycle 20 of a multiply clears outputs
      // immediately and abandons the operation.
      op    = 3'b000;
      a     = 32'd5;
      b     = 32'd6;
      rdIn  = 5'd24;
      start = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      rstN  = 1'b0;
      start = 1'b0;
      mdlValid = 1'b0;
      #1;
      checkOutput("midReset_done",   {31'b0, done},  32'd0);
      checkOutput("midReset_result", result,         32'd0);
      checkOutput("midReset_rd",     {27'b0, rdOut}, 32'd0);
      checkOutput("midReset_stall",  {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      watchNoDone(40, "midReset_noDone");

      // Quotient then remainder of the same operands; the second completes
      // in one cycle only when the result cache is built in.
      applyStimulus(3'b100, 32'd100, 32'd7, 5'd25, 32'd14, "cacheDiv");
      applyStimulus(3'b110, 32'd100, 32'd7, 5'd26, 32'd2,  "cacheRem");

      if (scoreboard.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
